// File: rtl/byte_link_pkg.sv
// Shared types for the byte-link arbiter: link word layout and field helpers.
package byte_link_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PRIO_W = 2;
    localparam int unsigned WORD_W = BYTE_W + PRIO_W;

    typedef struct packed {
        logic [PRIO_W-1:0] prio;
        logic [BYTE_W-1:0] data;
    } link_word_t;

    function automatic logic [PRIO_W-1:0] prio_of(input link_word_t w);
        return w.prio;
    endfunction

endpackage

// File: rtl/byte_link_fifo.sv
// Per-source word FIFO; a push into a full FIFO is taken only when a pop frees a slot that cycle.
module byte_link_fifo
    import byte_link_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  link_word_t din,
    input  logic       pop,
    output link_word_t dout,
    output logic       empty,
    output logic       full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    link_word_t  mem [DEPTH];
    logic        do_pop;
    logic        do_push;

    // Extra wrap bit distinguishes full from empty when the low bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/byte_link_arbiter.sv
// Merges N_SRC buffered byte streams onto one registered valid/ready link:
// highest prio head wins, round-robin among equal prios.
module byte_link_arbiter
    import byte_link_pkg::*;
#(
    parameter  int unsigned N_SRC      = 2,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC*WORD_W-1:0] in_data,
    input  logic [N_SRC-1:0]        in_req,
    output logic [WORD_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_SRC-1:0]        overflow
);

    link_word_t        head [N_SRC];
    logic [N_SRC-1:0]  empty;
    logic [N_SRC-1:0]  full;
    logic [N_SRC-1:0]  pop;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  idx;
    logic [PRIO_W-1:0] best_prio;
    logic              any_ne;
    logic              found;
    logic              load_en;
    logic              load;

    for (genvar i = 0; i < N_SRC; i++) begin : g_fifo
        byte_link_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (in_req[i]),
            .din   (link_word_t'(in_data[WORD_W*i +: WORD_W])),
            .pop   (pop[i]),
            .dout  (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
        assign pop[i] = load & (grant == SRC_W'(i));
    end

    // Grant: find the top head prio, then the first holder of it at or after rr_ptr.
    always_comb begin
        best_prio = '0;
        any_ne    = 1'b0;
        grant     = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!empty[i]) begin
                any_ne = 1'b1;
                if (prio_of(head[i]) > best_prio) best_prio = prio_of(head[i]);
            end
        end
        for (int unsigned k = 0; k < N_SRC; k++) begin
            idx = SRC_W'((32'(rr_ptr) + k) % N_SRC);
            if (!found && !empty[idx] && (prio_of(head[idx]) == best_prio)) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign load_en = ~out_valid | out_ready;
    assign load    = load_en & any_ne;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
            overflow  <= '0;
        end else begin
            overflow <= overflow | (in_req & full & ~pop);
            if (load_en) begin
                if (any_ne) begin
                    out_data  <= head[grant];
                    out_src   <= grant;
                    out_valid <= 1'b1;
                    rr_ptr    <= (grant == SRC_W'(N_SRC - 1)) ? '0 : grant + SRC_W'(1);
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_link_arbiter.sv
// Randomised and directed bench for byte_link_arbiter against a queue-based link model.
module tb_byte_link_arbiter;

    localparam int N = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] in_data;
    logic [1:0]  in_req;
    logic [9:0]  out_data;
    logic [0:0]  out_src;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  overflow;

    int vectors = 0;
    int miscompares = 0;

    byte_link_arbiter #(.N_SRC(N), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_req    (in_req),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Model state: one queue per source plus the visible output word.
    logic [9:0]  mq [N][$];
    logic        m_valid = 1'b0;
    logic [9:0]  m_data = '0;
    int          m_src = 0;
    int          m_rr = 0;
    logic [1:0]  m_ovf = '0;
    logic [10:0] hs_q [$];
    logic [10:0] exp_q [$];

    function automatic void check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step();
        int best;
        int bp;
        int i;
        if (reset) begin
            for (int s = 0; s < N; s++) mq[s].delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_rr    = 0;
            m_ovf   = '0;
            return;
        end
        if (!m_valid || out_ready) begin
            best = -1;
            bp   = -1;
            for (int k = 0; k < N; k++) begin
                i = (m_rr + k) % N;
                if (mq[i].size() > 0 && int'(mq[i][0][9:8]) > bp) begin
                    bp   = int'(mq[i][0][9:8]);
                    best = i;
                end
            end
            if (best >= 0) begin
                m_data  = mq[best].pop_front();
                m_src   = best;
                m_valid = 1'b1;
                m_rr    = (best + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int s = 0; s < N; s++) begin
            if (in_req[s]) begin
                if (mq[s].size() < D) mq[s].push_back(in_data[10*s +: 10]);
                else m_ovf[s] = 1'b1;
            end
        end
    endfunction

    // Compare process: log handshakes, advance the model, check just after the edge.
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) hs_q.push_back({out_src, out_data});
        model_step();
        #1;
        check("out_valid", int'(out_valid), int'(m_valid));
        if (m_valid) begin
            check("out_data", int'(out_data), int'(m_data));
            check("out_src", int'(out_src), m_src);
        end
        check("overflow", int'(overflow), int'(m_ovf));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_req = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        in_req = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_one(input int src, input logic [9:0] w);
        @(negedge clk);
        in_req = '0;
        in_req[src] = 1'b1;
        in_data[10*src +: 10] = w;
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, hs_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < hs_q.size(); j++)
            check(name, int'(hs_q[j]), int'(exp_q[j]));
    endtask

    logic [9:0] words [16] = '{10'h008, 10'h199, 10'h275, 10'h3E9, 10'h025, 10'h1B3,
                               10'h2C4, 10'h05F, 10'h3A0, 10'h111, 10'h26E, 10'h0D2,
                               10'h347, 10'h18C, 10'h2F1, 10'h03B};

    initial begin
        reset     = 1'b1;
        in_req    = '0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_valid", int'(out_valid), 0);
        check("rst_ovf", int'(overflow), 0);

        // Single source stream, latency and ordering
        hs_q.delete();
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 1) check("lat_t1", int'(out_valid), 0);
            if (k == 2) check("lat_t2", int'(out_valid), 1);
            in_req  = 2'b10;
            in_data = {words[k], 10'h000};
            exp_q.push_back({1'b1, words[k]});
        end
        idle(5);
        check_log("single");
        check("single_ovf", int'(overflow), 0);

        // Priority beats round-robin
        hs_q.delete();
        exp_q.delete();
        @(negedge clk);
        in_req  = 2'b11;
        in_data = {10'h355, 10'h1AA};
        idle(4);
        exp_q.push_back({1'b1, 10'h355});
        exp_q.push_back({1'b0, 10'h1AA});
        check_log("prio");

        // Equal prio alternates from src0 after reset
        do_reset();
        hs_q.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_req  = 2'b11;
            in_data = {10'(10'h280 + k), 10'(10'h200 + k)};
        end
        idle(14);
        check("tie_len", int'(hs_q.size() >= 8), 1);
        for (int j = 0; j < 8 && j < hs_q.size(); j++)
            check("tie_src", int'(hs_q[j][10]), j % 2);

        // Backpressure: hold word1, drop word6
        do_reset();
        hs_q.delete();
        exp_q.delete();
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) push_one(0, 10'(10'h100 + k));
        idle(3);
        check("bp_ovf", int'(overflow), 1);
        check("bp_valid", int'(out_valid), 1);
        check("bp_hold", int'(out_data), 10'h101);
        @(negedge clk);
        out_ready = 1'b1;
        idle(8);
        for (int k = 1; k <= 5; k++) exp_q.push_back({1'b0, 10'(10'h100 + k)});
        check_log("bp");

        // Push into a full FIFO while it pops
        do_reset();
        hs_q.delete();
        exp_q.delete();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) push_one(0, 10'(10'h040 + k));
        @(negedge clk);
        out_ready = 1'b1;
        in_req    = 2'b01;
        in_data   = {10'h000, 10'h046};
        idle(8);
        check("fp_ovf", int'(overflow), 0);
        for (int k = 1; k <= 6; k++) exp_q.push_back({1'b0, 10'(10'h040 + k)});
        check_log("fullpop");

        // Reset while loaded and overflowed
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_req  = 2'b11;
            in_data = {10'(10'h2C0 + k), 10'(10'h230 + k)};
        end
        idle(1);
        check("pre_rst_ovf", int'(overflow), 3);
        hs_q.delete();
        do_reset();
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ovf", int'(overflow), 0);
        out_ready = 1'b1;
        idle(3);
        check("mid_rst_quiet", hs_q.size(), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_req  = 2'b11;
            in_data = {10'h2AA, 10'h255};
        end
        idle(6);
        check("restart_len", hs_q.size(), 4);
        if (hs_q.size() >= 2) begin
            check("restart_src0", int'(hs_q[0][10]), 0);
            check("restart_src1", int'(hs_q[1][10]), 1);
        end

        // Random traffic with random backpressure and rare resets
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 299) == 0);
            in_req    = 2'($urandom);
            in_data   = 20'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        idle(12);
        check("drain_valid", int'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
